// File: rtl/ring_heater_ctrl_if.sv
// ring_heater_ctrl_if: command handshake between a heater-bank source and ring_heater_ctrl
interface ring_heater_ctrl_if #(
  parameter int NUM_RINGS = 8,
  parameter int DUTY_W    = 8
);
  logic                             cmd_valid;
  logic                             cmd_ready;
  logic [$clog2(NUM_RINGS+1)-1:0]   cmd_rings;
  logic [DUTY_W-1:0]                cmd_duty;
  modport master(output cmd_valid, cmd_rings, cmd_duty, input cmd_ready);
  modport slave(input cmd_valid, cmd_rings, cmd_duty, output cmd_ready);
endinterface

// File: rtl/ring_heater_ctrl.sv
// ring_heater_ctrl: ramps, PWM-gates and start-watchdogs a bank of ring-oscillator heaters
module ring_heater_ctrl #(
  parameter int NUM_RINGS      = 8,
  parameter int DUTY_W         = 8,
  parameter int STEP_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  ring_heater_ctrl_if.slave              cmd,
  output logic [NUM_RINGS-1:0]           ring_enable,
  input  logic [NUM_RINGS-1:0]           ring_running,
  output logic [$clog2(NUM_RINGS+1)-1:0] active_count,
  output logic                           busy,
  output logic [NUM_RINGS-1:0]           fault_mask,
  output logic                           fault
);
  localparam int CW = $clog2(NUM_RINGS+1);
  localparam int SW = $clog2(STEP_CYCLES+1);
  localparam int WW = $clog2(TIMEOUT_CYCLES+1);
  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN, HOLD} state_e;
  state_e               state_q, state_d;
  logic [NUM_RINGS-1:0] mask_q, mask_d, en_q, en_d, fmask_q, fmask_d, s1_q, s2_q;
  logic [NUM_RINGS-1:0] free, up_oh, dn_oh;
  logic [CW-1:0]        cnt_q, cnt_d, tgt_q, tgt_d, tgt_in, base_cnt;
  logic [DUTY_W-1:0]    duty_q, duty_d, pwm_q;
  logic [SW-1:0]        step_q, step_d;
  logic [WW-1:0]        wd_q, wd_d;
  logic                 accept, pwm_on;
  function automatic logic [CW-1:0] popcnt(input logic [NUM_RINGS-1:0] v);
    popcnt = '0;
    for (int i = 0; i < NUM_RINGS; i++) popcnt = popcnt + CW'(v[i]);
  endfunction
  assign cmd.cmd_ready = ~rst & (state_q == IDLE || state_q == HOLD);
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign tgt_in        = (cmd.cmd_rings > CW'(NUM_RINGS)) ? CW'(NUM_RINGS) : cmd.cmd_rings;
  assign pwm_on        = pwm_q < duty_q;
  assign ring_enable   = en_q;
  assign active_count  = cnt_q;
  assign busy          = state_q == RAMP_UP || state_q == RAMP_DOWN;
  assign fault_mask    = fmask_q;
  assign fault         = |fmask_q;
  // Faulted rings leave the mask first so a same-cycle ramp step sees the reduced set.
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    duty_d   = duty_q;
    mask_d   = mask_q & ~fmask_q;
    step_d   = (step_q == '0) ? SW'(STEP_CYCLES - 1) : step_q - 1'b1;
    free     = ~mask_d & ~fmask_q;
    up_oh    = free & (~free + 1'b1);
    dn_oh    = '0;
    for (int i = 0; i < NUM_RINGS; i++) if (mask_d[i]) dn_oh = NUM_RINGS'(1) << i;
    base_cnt = popcnt(mask_d);
    if (accept) begin
      tgt_d   = tgt_in;
      duty_d  = cmd.cmd_duty;
      step_d  = '0;
      state_d = (tgt_in > cnt_q) ? RAMP_UP : (tgt_in < cnt_q) ? RAMP_DOWN :
                (tgt_in == '0) ? IDLE : HOLD;
    end else if (step_q == '0 && state_q == RAMP_UP) begin
      if (up_oh == '0) begin
        tgt_d   = base_cnt;
        state_d = HOLD;
      end else begin
        mask_d  = mask_d | up_oh;
        state_d = (base_cnt + 1'b1 >= tgt_q) ? HOLD : RAMP_UP;
      end
    end else if (step_q == '0 && state_q == RAMP_DOWN) begin
      mask_d  = (base_cnt > tgt_q) ? mask_d & ~dn_oh : mask_d;
      state_d = (base_cnt > tgt_q + 1'b1) ? RAMP_DOWN : (tgt_q == '0) ? IDLE : HOLD;
    end
    cnt_d   = popcnt(mask_d);
    en_d    = mask_d & ~fmask_q & {NUM_RINGS{pwm_on}};
    wd_d    = (en_d != en_q) ? '0 : (wd_q == WW'(TIMEOUT_CYCLES)) ? wd_q : wd_q + 1'b1;
    fmask_d = (en_d == en_q && wd_q == WW'(TIMEOUT_CYCLES - 1)) ? fmask_q | (en_q & ~s2_q) : fmask_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      en_q    <= '0;
      fmask_q <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      duty_q  <= '0;
      pwm_q   <= '0;
      step_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      en_q    <= en_d;
      fmask_q <= fmask_d;
      s1_q    <= ring_running;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_q + 1'b1;
      step_q  <= step_d;
      wd_q    <= wd_d;
    end
  end
endmodule

// File: tb/tb_ring_heater_ctrl.sv
// tb_ring_heater_ctrl: directed scoreboard bench for ring_heater_ctrl
module tb_ring_heater_ctrl;
  logic       clk = 0;
  logic       rst = 0;
  logic [7:0] ring_enable, ring_running, fault_mask;
  logic [7:0] stuck = '0;
  logic [3:0] active_count;
  logic       busy, fault;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  typedef struct {
    int         due;
    string      name;
    logic [7:0] en;
    logic [3:0] cnt;
    logic       busy;
    logic [7:0] fm;
    logic       rdy;
  } exp_t;
  exp_t sb[$];
  ring_heater_ctrl_if #(.NUM_RINGS(8), .DUTY_W(8)) cmd_if ();
  ring_heater_ctrl #(.NUM_RINGS(8), .DUTY_W(8), .STEP_CYCLES(16), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if), .ring_enable(ring_enable), .ring_running(ring_running),
    .active_count(active_count), .busy(busy), .fault_mask(fault_mask), .fault(fault)
  );
  assign ring_running = ring_enable & ~stuck;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic expect_at(input int due, input string nm, input logic [7:0] en, input int cnt,
                           input logic bz, input logic [7:0] fm, input logic rdy);
    exp_t e;
    int   p;
    e = '{due, nm, en, 4'(cnt), bz, fm, rdy};
    p = sb.size();
    while (p > 0 && sb[p-1].due > due) p--;
    sb.insert(p, e);
  endtask
  initial forever begin
    exp_t e;
    @(posedge clk);
    #2;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      vectors++;
      if (e.due < cyc) begin
        miscompares++;
        $display("FAIL %s: not sampled at cycle %0d (now %0d)", e.name, e.due, cyc);
      end else if (ring_enable !== e.en || active_count !== e.cnt || busy !== e.busy ||
                   fault_mask !== e.fm || fault !== (|e.fm) || cmd_if.cmd_ready !== e.rdy) begin
        miscompares++;
        $display("FAIL %s @%0d: got en=%h cnt=%0d busy=%b fm=%h flt=%b rdy=%b, want en=%h cnt=%0d busy=%b fm=%h flt=%b rdy=%b",
                 e.name, cyc, ring_enable, active_count, busy, fault_mask, fault, cmd_if.cmd_ready,
                 e.en, e.cnt, e.busy, e.fm, |e.fm, e.rdy);
      end
    end
  end
  task automatic do_reset(output int r);
    @(negedge clk);
    rst = 1;
    expect_at(cyc + 2, "reset", 8'h00, 0, 0, 8'h00, 0);
    @(negedge clk);
    @(negedge clk);
    r   = cyc;
    rst = 0;
  endtask
  task automatic send(input int rings, input int duty, output int t);
    @(negedge clk);
    cmd_if.cmd_valid = 1;
    cmd_if.cmd_rings = 4'(rings);
    cmd_if.cmd_duty  = 8'(duty);
    for (int k = 0; k < 2000 && !cmd_if.cmd_ready; k++) @(negedge clk);
    if (!cmd_if.cmd_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept: cmd_ready=%b after 2000 cycles, want 1", cmd_if.cmd_ready);
    end
    t = cyc + 1;
    @(negedge clk);
    cmd_if.cmd_valid = 0;
  endtask
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  initial begin
    int r1, r2, t, e0;
    cmd_if.cmd_valid = 0;
    cmd_if.cmd_rings = '0;
    cmd_if.cmd_duty  = '0;
    do_reset(r1);
    send(3, 255, t);
    expect_at(t + 1,  "up3_step1",  8'h01, 1, 1, 8'h00, 0);
    expect_at(t + 16, "up3_gap",    8'h01, 1, 1, 8'h00, 0);
    expect_at(t + 17, "up3_step2",  8'h03, 2, 1, 8'h00, 0);
    expect_at(t + 33, "up3_done",   8'h07, 3, 0, 8'h00, 1);
    wait_until(t + 34);
    send(1, 255, t);
    expect_at(t + 1,  "dn1_step1",  8'h03, 2, 1, 8'h00, 0);
    expect_at(t + 17, "dn1_done",   8'h01, 1, 0, 8'h00, 1);
    expect_at(t + 90, "dn1_nofault", 8'h01, 1, 0, 8'h00, 1);
    wait_until(t + 90);
    send(15, 255, t);
    expect_at(t + 1,  "clamp_step1", 8'h03, 2, 1, 8'h00, 0);
    expect_at(t + 96, "clamp_pre",   8'h7F, 7, 1, 8'h00, 0);
    expect_at(t + 97, "clamp_full",  8'hFF, 8, 0, 8'h00, 1);
    wait_until(t + 97);
    send(8, 64, t);
    e0 = r1 + 1;
    while (e0 <= t + 1) e0 += 256;
    expect_at(e0 + 63,  "pwm_last_on",  8'hFF, 8, 0, 8'h00, 1);
    expect_at(e0 + 64,  "pwm_first_off", 8'h00, 8, 0, 8'h00, 1);
    expect_at(e0 + 255, "pwm_last_off", 8'h00, 8, 0, 8'h00, 1);
    expect_at(e0 + 256, "pwm_rewrap",   8'hFF, 8, 0, 8'h00, 1);
    wait_until(e0 + 256);
    do_reset(r2);
    stuck = 8'h04;
    send(4, 255, t);
    expect_at(t + 112, "wd_prefault", 8'h0F, 4, 0, 8'h00, 1);
    expect_at(t + 113, "wd_fault",    8'h0F, 4, 0, 8'h04, 1);
    expect_at(t + 114, "wd_drop",     8'h0B, 3, 0, 8'h04, 1);
    wait_until(t + 114);
    send(8, 255, t);
    expect_at(t + 1, "skip_faulted", 8'h1B, 4, 1, 8'h04, 0);
    wait_until(t + 5);
    expect_at(t + 6, "midramp_rst", 8'h00, 0, 0, 8'h00, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    expect_at(t + 7, "post_rst_ready", 8'h00, 0, 0, 8'h00, 1);
    for (int k = 0; k < 500 && sb.size() > 0; k++) @(negedge clk);
    while (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: never sampled, due at cycle %0d", sb[0].name, sb[0].due);
      void'(sb.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ring_heater_ctrl.md
Name: ring_heater_ctrl

Overview:
- Upstream controller for the bank of ring-oscillator heater cells in the rp_heater reconfigurable module.
- Accepts a (ring count, duty) command and drives the per-ring `enable` inputs.
  - Ring count is ramped one ring at a time to limit supply di/dt.
  - Rings are PWM-gated by the duty value.
- Watches each ring's `running` output and latches a sticky fault for rings that fail to start. Faulted rings are excluded from further enabling.

Parameters:
- NUM_RINGS, 8: number of heater rings driven.
- DUTY_W, 8: duty/PWM counter width; PWM period is 2^DUTY_W cycles.
- STEP_CYCLES, 16: cycles between successive ring add/remove steps during a ramp (>=1).
- TIMEOUT_CYCLES, 64: cycles of unchanged ring_enable before running is checked (>=3).

Ports:
- clk  in  1  system clock; the single clock domain.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_rings  in  $clog2(NUM_RINGS+1)  target active ring count.
- cmd_duty  in  DUTY_W  PWM on-time per period.
- ring_enable  out  NUM_RINGS  registered enable to each ring.
- ring_running  in  NUM_RINGS  ring running status, asynchronous to clk.
- active_count  out  $clog2(NUM_RINGS+1)  rings currently in the ramp mask.
- busy  out  1  ramp in progress.
- fault_mask  out  NUM_RINGS  sticky per-ring start failure.
- fault  out  1  OR of fault_mask.

Behaviour:
- Reset values (outputs and state):
  - Reset takes effect the cycle after rst is sampled high, including mid-ramp.
  - cmd_ready=0 during rst, 1 the first cycle after.
  - ring_enable=0, active_count=0, busy=0, fault_mask=0, fault=0.
  - Internal state: IDLE, ramp mask=0, PWM counter=0, duty=0, synchronizers=0, watchdog=0.
- States: IDLE, RAMP_UP, RAMP_DOWN, HOLD.
  - cmd_ready=1 in IDLE and HOLD only.
  - busy=1 in RAMP_UP and RAMP_DOWN.
- Command accept: cmd_valid & cmd_ready at clock edge T.
  - target = min(cmd_rings, NUM_RINGS).
  - duty register loads cmd_duty and takes effect from T+1.
- Next state from accept, with cur = active_count:
  - target>cur -> RAMP_UP.
  - target<cur -> RAMP_DOWN.
  - target==cur!=0 -> HOLD.
  - target==cur==0 -> IDLE.
- Ramp stepping:
  - First step occurs at T+1; further steps every STEP_CYCLES cycles.
  - RAMP_UP: each step sets the lowest-index mask bit that is 0 and not faulted. active_count increments.
  - RAMP_DOWN: each step clears the highest-index set mask bit. active_count decrements.
  - Reaching target exits to HOLD in the same step, or to IDLE if target=0.
  - If no non-faulted ring remains during RAMP_UP, the target is truncated and the state goes to HOLD.
- PWM:
  - pwm_cnt free-runs 0..2^DUTY_W-1 and wraps.
  - pwm_on = (pwm_cnt < duty).
  - duty=0 means never on; maximum on-time is (2^DUTY_W-1)/2^DUTY_W.
- Enable output: ring_enable (registered) = mask & ~fault_mask & {NUM_RINGS{pwm_on}}.
- Running sync: 2-flop synchronizer per bit (run_s).
- Watchdog:
  - Counter clears whenever ring_enable changes value.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
  - On the cycle it first reaches TIMEOUT_CYCLES: fault_mask |= ring_enable & ~run_s.
  - fault_mask clears only on rst.
- Faulted ring handling: a newly faulted ring drops from ring_enable the next cycle and is cleared from the mask; active_count decrements in that same cycle.
- Simultaneous events:
  - Fault and ramp step in the same cycle: fault removal applies first, then the step.
  - A command presented while busy is held off by cmd_ready=0. The source must hold cmd_valid and its data.

Test Plan:
- Reset then cmd (rings=3, duty=255) at T -> ring_enable bit0 at T+1, bit1 at T+17, bit2 at T+33; busy deasserts at T+33; active_count=3; state HOLD.
- From HOLD with 3 rings, cmd rings=1 -> bit2 clears at T+1, bit1 at T+17; enable=0b001; no fault with ring_running tied to ring_enable.
- duty=64, rings=8, running mirrors enable -> enable high 64 of every 256 cycles; fault_mask stays 0.
- Ring 2 running stuck 0, cmd rings=4 duty=255 -> fault_mask=0x04 after 64 stable cycles; bit2 drops; active_count=3; enable=0x0B.
- cmd_rings=15 with NUM_RINGS=8 -> clamps to 8; enable=0xFF after 8 steps.
- rst asserted mid-RAMP_UP -> next cycle ring_enable=0, active_count=0, fault_mask=0, state IDLE; cmd_ready=1 the first cycle after rst deasserts.
